// File: rtl/ws2812_feeder.sv
// ---------------------------------------------------------------------------
// ws2812_feeder
//
// Store-and-forward buffer between a UART receiver and a ws2812 bit encoder.
// Received bytes are gathered into frames. A frame is closed by an end-of-frame
// marker, written either after IDLE_TIMEOUT quiet cycles or when the buffer is
// about to fill. The encoder only sees a frame once its marker is in the FIFO,
// so it can never run dry in the middle of a frame.
//
// Each FIFO entry is {marker, byte}. A marker entry is presented to the
// encoder as latch=1 with data=0.
//
// Parameters
//   DEPTH         FIFO entries (power of two, >= 4)
//   IDLE_TIMEOUT  quiet rx cycles that close an open frame (>= 2)
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset
//   rx_data      received UART byte
//   rx_valid     one-cycle strobe qualifying rx_data
//   data         byte presented to the encoder
//   latch        latch/reset request presented to the encoder
//   next         one-cycle strobe: encoder consumed data/latch this cycle
//   overflow     sticky error flag (byte dropped or frame split)
//   frames_sent  16-bit count of completed frames, only when
//                WS2812_FEEDER_STATS_EN is defined
// ---------------------------------------------------------------------------
module ws2812_feeder #(
  parameter int DEPTH        = 16,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  data,
  output logic        latch,
  input  logic        next,
  output logic        overflow
`ifdef WS2812_FEEDER_STATS_EN
  ,
  output logic [15:0] frames_sent
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT);

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } state_t;

  // Storage and bookkeeping
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] frames_pending;
  logic [IW-1:0] idle_cnt;
  logic          open_frame;
  state_t        state;

  // Per-cycle decisions
  logic          accept;
  logic          timeout_mark;
  logic          force_mark;
  logic          mark_wr;
  logic          push;
  logic [8:0]    wr_entry;
  logic          pop;
  logic          pop_mark;
  logic [8:0]    head;
  logic [8:0]    head_next;
  logic [AW-1:0] rd_next;

  always_comb begin
    // Data bytes may only use DEPTH-1 slots; the last slot is kept so the
    // marker that closes the frame always has somewhere to go.
    accept       = rx_valid && (count < CW'(DEPTH - 1));
    timeout_mark = open_frame && !rx_valid && (idle_cnt == IW'(IDLE_TIMEOUT - 1));
    // With nothing pending the drain side cannot free space, so an open frame
    // that fills the buffer must be split or the buffer would deadlock.
    force_mark   = open_frame && (count == CW'(DEPTH - 1)) && (frames_pending == '0);
    mark_wr      = timeout_mark || force_mark;
    // accept and force_mark are mutually exclusive (count < vs == DEPTH-1) and
    // timeout_mark needs rx_valid low, so at most one entry is written per cycle.
    push         = accept || mark_wr;
    wr_entry     = mark_wr ? 9'h100 : {1'b0, rx_data};
    pop          = (state == ST_DRAIN) && next;
    rd_next      = rd_ptr + 1'b1;
    head         = mem[rd_ptr];
    head_next    = mem[rd_next];
    pop_mark     = pop && head[8];
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the values from before this edge, regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      frames_pending <= '0;
      idle_cnt       <= '0;
      open_frame     <= 1'b0;
      overflow       <= 1'b0;
      state          <= ST_IDLE;
      data           <= 8'h00;
      latch          <= 1'b1;
`ifdef WS2812_FEEDER_STATS_EN
      frames_sent    <= '0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case ({mark_wr, pop_mark})
        2'b10:   frames_pending <= frames_pending + 1'b1;
        2'b01:   frames_pending <= frames_pending - 1'b1;
        default: frames_pending <= frames_pending;
      endcase

      if ((rx_valid && !accept) || force_mark) begin
        overflow <= 1'b1;
      end

      if (mark_wr) begin
        open_frame <= 1'b0;
      end else if (accept) begin
        open_frame <= 1'b1;
      end

      if (accept || mark_wr) begin
        idle_cnt <= '0;
      end else if (open_frame && !rx_valid) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      // Outputs are registered: on every transition the entry that becomes
      // the head on the next cycle is loaded straight from the array.
      case (state)
        ST_IDLE: begin
          data  <= 8'h00;
          latch <= 1'b1;
          if (frames_pending != '0) begin
            state <= ST_DRAIN;
            data  <= head[7:0];
            latch <= head[8];
          end
        end
        ST_DRAIN: begin
          if (pop) begin
            if (head[8]) begin
              state <= ST_IDLE;
              data  <= 8'h00;
              latch <= 1'b1;
            end else begin
              // The current frame's marker is still behind the head, so the
              // following entry is always valid here.
              data  <= head_next[7:0];
              latch <= head_next[8];
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          data  <= 8'h00;
          latch <= 1'b1;
        end
      endcase

`ifdef WS2812_FEEDER_STATS_EN
      if (pop_mark) begin
        frames_sent <= frames_sent + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ws2812_feeder.sv
// ---------------------------------------------------------------------------
// tb_ws2812_feeder
//
// Directed bench for ws2812_feeder with DEPTH=16, IDLE_TIMEOUT=8. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, i.e. just after the edge that produced them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ws2812_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  data;
  logic        latch;
  logic        next = 1'b0;
  logic        overflow;
`ifdef WS2812_FEEDER_STATS_EN
  logic [15:0] frames_sent;
`endif

  int checks = 0;
  int errors = 0;

  ws2812_feeder #(
    .DEPTH       (16),
    .IDLE_TIMEOUT(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .data    (data),
    .latch   (latch),
    .next    (next),
    .overflow(overflow)
`ifdef WS2812_FEEDER_STATS_EN
    ,
    .frames_sent(frames_sent)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_data, input logic exp_latch);
    check({tag, ".data"}, 32'(data), 32'(exp_data));
    check({tag, ".latch"}, 32'(latch), 32'(exp_latch));
  endtask

  // One clock cycle with the given inputs; returns 1 unit after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic n);
    rx_valid = v;
    rx_data  = d;
    next     = n;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    next     = 1'b0;
  endtask

  initial begin
    // ---- Reset, with rx_valid and next active (both must be ignored) ----
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    reset = 1'b0;
    check_out("reset", 8'h00, 1'b1);
    check("reset.overflow", 32'(overflow), 32'd0);
    check("reset.count", 32'(dut.count), 32'd0);

    // ---- No input: next strobes change nothing ----
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check_out("idle_next", 8'h00, 1'b1);
    end
    check("idle_next.count", 32'(dut.count), 32'd0);

    // ---- Frame 00,01,02 closed by 8 idle cycles ----
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    check("f1.count", 32'(dut.count), 32'd3);
    repeat (7) step(1'b0, 8'h00, 1'b0);
    check("f1.no_mark_yet", 32'(dut.frames_pending), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    check("f1.fp_after_mark", 32'(dut.frames_pending), 32'd1);
    check("f1.count_mark", 32'(dut.count), 32'd4);
    check_out("f1.still_idle", 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check_out("f1.b0", 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_out("f1.b1", 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_out("f1.b2", 8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_out("f1.latch", 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check_out("f1.back_idle", 8'h00, 1'b1);
    check("f1.fp_end", 32'(dut.frames_pending), 32'd0);
    check("f1.count_end", 32'(dut.count), 32'd0);
    check("f1.state_end", 32'(dut.state), 32'd0);

    // ---- 0x55, 7-cycle gap, 0xAA, 8-cycle gap: one frame ----
    step(1'b1, 8'h55, 1'b0);
    repeat (7) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    check("f2.gap_no_mark", 32'(dut.frames_pending), 32'd0);
    check("f2.count", 32'(dut.count), 32'd2);
    repeat (7) step(1'b0, 8'h00, 1'b0);
    check("f2.no_mark_yet", 32'(dut.frames_pending), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    check("f2.fp", 32'(dut.frames_pending), 32'd1);
    check("f2.count_mark", 32'(dut.count), 32'd3);
    step(1'b0, 8'h00, 1'b0);
    check_out("f2.b0", 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_out("f2.b1", 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_out("f2.latch", 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("f2.fp_end", 32'(dut.frames_pending), 32'd0);
    check("f2.count_end", 32'(dut.count), 32'd0);
    check("f2.overflow", 32'(overflow), 32'd0);

    // ---- 20 back-to-back bytes, no drain: 15 kept, forced marker ----
    for (int i = 1; i <= 20; i++) step(1'b1, 8'(i), 1'b0);
    check("ovf.flag", 32'(overflow), 32'd1);
    check("ovf.count", 32'(dut.count), 32'd16);
    check("ovf.fp", 32'(dut.frames_pending), 32'd1);
    check_out("ovf.b1", 8'h01, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check_out($sformatf("ovf.b%0d", i), 8'(i), 1'b0);
    end
    step(1'b0, 8'h00, 1'b1);
    check_out("ovf.latch", 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("ovf.fp_end", 32'(dut.frames_pending), 32'd0);
    check("ovf.count_end", 32'(dut.count), 32'd0);
    check("ovf.sticky", 32'(overflow), 32'd1);
`ifdef WS2812_FEEDER_STATS_EN
    check("stats.three", 32'(frames_sent), 32'd3);
`endif

    // ---- Second frame received while the first drains ----
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    check("ovl.ovf_cleared", 32'(overflow), 32'd0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    repeat (8) step(1'b0, 8'h00, 1'b0);
    check("ovl.fpA", 32'(dut.frames_pending), 32'd1);
    check("ovl.countA", 32'(dut.count), 32'd4);
    step(1'b0, 8'h00, 1'b0);
    check_out("ovl.a0", 8'h11, 1'b0);
    step(1'b1, 8'h44, 1'b1);
    check_out("ovl.a1", 8'h22, 1'b0);
    check("ovl.count1", 32'(dut.count), 32'd4);
    step(1'b1, 8'h55, 1'b1);
    check_out("ovl.a2", 8'h33, 1'b0);
    check("ovl.count2", 32'(dut.count), 32'd4);
    step(1'b1, 8'h66, 1'b1);
    check_out("ovl.a_latch", 8'h00, 1'b1);
    check("ovl.count3", 32'(dut.count), 32'd4);
    step(1'b0, 8'h00, 1'b1);
    check_out("ovl.a_done", 8'h00, 1'b1);
    check("ovl.fp_between", 32'(dut.frames_pending), 32'd0);
    check("ovl.count_between", 32'(dut.count), 32'd3);
    repeat (6) step(1'b0, 8'h00, 1'b0);
    check("ovl.B_no_mark_yet", 32'(dut.frames_pending), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    check("ovl.fpB", 32'(dut.frames_pending), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check_out("ovl.b0", 8'h44, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_out("ovl.b1", 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_out("ovl.b2", 8'h66, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_out("ovl.b_latch", 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("ovl.count_end", 32'(dut.count), 32'd0);
    check("ovl.fp_end", 32'(dut.frames_pending), 32'd0);

    // ---- Reset asserted mid-drain ----
    for (int i = 1; i <= 20; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    check_out("mid.b1", 8'h81, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_out("mid.b2", 8'h82, 1'b0);
    check("mid.ovf", 32'(overflow), 32'd1);
`ifdef WS2812_FEEDER_STATS_EN
    check("stats.two", 32'(frames_sent), 32'd2);
`endif
    reset = 1'b1;
    step(1'b1, 8'hEE, 1'b1);
    reset = 1'b0;
    check_out("mid.reset", 8'h00, 1'b1);
    check("mid.reset_ovf", 32'(overflow), 32'd0);
    check("mid.reset_count", 32'(dut.count), 32'd0);
    check("mid.reset_fp", 32'(dut.frames_pending), 32'd0);
`ifdef WS2812_FEEDER_STATS_EN
    check("stats.reset", 32'(frames_sent), 32'd0);
`endif
    step(1'b0, 8'h00, 1'b1);
    check_out("mid.after", 8'h00, 1'b1);
    check("mid.after_count", 32'(dut.count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_feeder.md
WS2812_FEEDER -- requirements
Module: ws2812_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries, power of two, minimum 4.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 1000, number of rx-idle clock cycles that close a frame, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port rx_data  input  8  received UART byte.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port data  output  8  byte presented to the downstream ws2812 encoder.
REQ-008 SHALL have port latch  output  1  latch/reset request presented to the ws2812 encoder.
REQ-009 SHALL have port next  input  1  one-cycle strobe from the ws2812 encoder indicating data/latch were consumed this cycle.
REQ-010 SHALL have port overflow  output  1  sticky error flag.

Function
REQ-011 SHALL store entries of 9 bits {marker, byte} in a circular FIFO of DEPTH entries with wrap-around read/write pointers and a count register.
REQ-012 SHALL accept rx_data as a data entry (marker=0) when rx_valid=1 and count < DEPTH-1; otherwise the byte is dropped and overflow is set.
REQ-013 SHALL keep one slot reserved so a marker write never fails.
REQ-014 SHALL keep an open_frame flag, set on each accepted data byte, cleared when a marker is written.
REQ-015 SHALL use an idle counter: cleared on an accepted byte; incremented each cycle without rx_valid while open_frame=1; on the cycle it equals IDLE_TIMEOUT-1 with rx_valid=0, a marker entry (marker=1, byte=0) is written.
REQ-016 SHALL force-write a marker and set overflow when count reaches DEPTH-1 while open_frame=1 and frames_pending=0 (frame split, no deadlock).
REQ-017 SHALL keep frames_pending: +1 per marker write, -1 per marker pop, unchanged when both occur in one cycle.
REQ-018 SHALL implement a two-state FSM: IDLE, DRAIN.
REQ-019 IDLE: data=0, latch=1; next strobes pop nothing; go to DRAIN on the edge where frames_pending != 0.
REQ-020 DRAIN: data=head byte, latch=head marker; on next, pop head; if the popped entry is a marker, decrement frames_pending and return to IDLE.
REQ-021 SHALL allow push and pop in the same cycle, with count unchanged.
REQ-022 A marker written at edge E SHALL give frames_pending=1 after E, state=DRAIN after E+1, and the first frame byte on data after E+1.
REQ-023 SHALL never present a frame byte before that frame's marker is in the FIFO (store-and-forward, no mid-frame underrun).

Reset
REQ-024 SHALL, on reset=1 at a clock edge, clear pointers, count, frames_pending, idle counter, open_frame and overflow, and enter IDLE (data=0, latch=1), regardless of any frame in progress; rx_valid and next during reset SHALL be ignored.
REQ-025 overflow SHALL clear only by reset.

Configuration
REQ-026 With macro WS2812_FEEDER_STATS_EN defined, SHALL add output frames_sent (16 bits), incremented on each marker pop, wrapping 0xFFFF->0, cleared by reset.
REQ-027 Without WS2812_FEEDER_STATS_EN, SHALL have no frames_sent port and no counter logic.

Verification (DEPTH=16, IDLE_TIMEOUT=8)
REQ-028 SHALL check reset, no input: data=0, latch=1 indefinitely; next strobes do not change outputs.
REQ-029 SHALL check bytes 0x00,0x01,0x02 then 8 idle cycles -> marker written; outputs 0x00,0x01,0x02 on successive next strobes, then latch=1 on the 4th; IDLE after it; frames_pending=0.
REQ-030 SHALL check 0x55, 7 idle cycles, 0x AA, 8 idle cycles -> single frame 0x55,0xAA,latch; no marker after the first gap.
REQ-031 SHALL check 20 back-to-back bytes with next held 0 -> first 15 accepted, forced marker at count=15, bytes 16-20 dropped, overflow=1; drain yields 15 bytes then latch.
REQ-032 SHALL check a second frame received while the first is draining, with push and pop in the same cycle -> count correct, frames drained in order, each closed by latch.
REQ-033 SHALL check reset asserted mid-drain -> next cycle data=0, latch=1, overflow=0, FIFO empty; with WS2812_FEEDER_STATS_EN, frames_sent=0.
